alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational signed ALU. Performs the same eight signed operations on `WIDTH`-bit operands and produces a `2*WIDTH`-bit signed result with status flags. Uses a valid/ready interface on input and output and a registered result. Multiply is iterative, which keeps timing closure independent of `WIDTH`. Sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked signed ALU, 2*WIDTH-bit registered result, iterative shift-add multiply.
// Optional flag outputs compiled in with `define ALU_PIPE_FLAGS_EN (tied to 0 otherwise).
//
// state  | meaning
// S_IDLE | no multiply in progress; accepts operands when the output slot can take a result
// S_MUL  | iterating a multiply, r_cnt counts 0..WIDTH-1, one partial product per cycle
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [2:0]           i_opcode,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_flag_zero,
    output logic                 o_flag_neg,
    output logic                 o_flag_ovf
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [RW-1:0]      r_acc;
    logic [RW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [RW-1:0]      r_result;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_mul_done;
    logic               w_load;
    logic [RW-1:0]      w_a_ext;
    logic [RW-1:0]      w_b_ext;
    logic [WIDTH-1:0]   w_logic;
    logic [RW-1:0]      w_pp;
    logic [RW-1:0]      w_acc_next;
    logic [RW-1:0]      w_next_result;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && i_opcode == OP_MUL) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = (r_state == S_IDLE) && (!r_out_valid || i_out_ready);
        w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    end

    assign w_accept = i_in_valid && o_in_ready;
    assign w_load   = (w_accept && i_opcode != OP_MUL) || w_mul_done;
    assign w_a_ext  = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext  = {{WIDTH{i_b[WIDTH-1]}}, i_b};

    // The multiplier MSB carries negative weight, so the last partial product is subtracted.
    assign w_pp       = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = (r_cnt == CNT_LAST) ? (r_acc - w_pp) : (r_acc + w_pp);

    always_comb begin
        w_logic       = '0;
        w_next_result = '0;
        if (w_mul_done) begin
            w_next_result = w_acc_next;
        end else begin
            case (i_opcode)
                OP_ADD: w_next_result = w_a_ext + w_b_ext;
                OP_SUB: w_next_result = w_a_ext - w_b_ext;
                OP_AND: w_logic = i_a & i_b;
                OP_OR:  w_logic = i_a | i_b;
                OP_XOR: w_logic = i_a ^ i_b;
                OP_SHL: w_next_result = {w_a_ext[RW-2:0], 1'b0};
                OP_SHR: w_next_result = {w_a_ext[RW-1], w_a_ext[RW-1:1]};
                default: w_next_result = '0;
            endcase
            if (i_opcode == OP_AND || i_opcode == OP_OR || i_opcode == OP_XOR)
                w_next_result = {{WIDTH{w_logic[WIDTH-1]}}, w_logic};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && i_opcode == OP_MUL) begin
                r_acc    <= '0;
                r_mcand  <= w_a_ext;
                r_mplier <= i_b;
                r_cnt    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= {r_mcand[RW-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= w_mul_done ? '0 : r_cnt + 1'b1;
            end
            if (w_load) begin
                r_result    <= w_next_result;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_result    = r_result;
    assign o_out_valid = r_out_valid;

`ifdef ALU_PIPE_FLAGS_EN
    logic r_flag_zero;
    logic r_flag_neg;
    logic r_flag_ovf;
    logic w_ovf_en;
    logic w_fits;

    // Fits in signed WIDTH bits when the top WIDTH+1 bits are all equal.
    always_comb begin
        w_ovf_en = w_mul_done || i_opcode == OP_ADD || i_opcode == OP_SUB || i_opcode == OP_SHL;
        w_fits   = (&w_next_result[RW-1:WIDTH-1]) || !(|w_next_result[RW-1:WIDTH-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag_zero <= 1'b0;
            r_flag_neg  <= 1'b0;
            r_flag_ovf  <= 1'b0;
        end else if (w_load) begin
            r_flag_zero <= (w_next_result == '0);
            r_flag_neg  <= w_next_result[RW-1];
            r_flag_ovf  <= w_ovf_en && !w_fits;
        end
    end

    assign o_flag_zero = r_flag_zero;
    assign o_flag_neg  = r_flag_neg;
    assign o_flag_ovf  = r_flag_ovf;
`else
    assign o_flag_zero = 1'b0;
    assign o_flag_neg  = 1'b0;
    assign o_flag_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=4: directed vector table, handshake corner sequences,
// and randomized streaming against an integer-arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 4;
`ifdef ALU_PIPE_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     opcode = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           flag_zero, flag_neg, flag_ovf;

    int checks = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_opcode(opcode), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_result(result),
        .o_flag_zero(flag_zero), .o_flag_neg(flag_neg), .o_flag_ovf(flag_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           z;
        logic           n;
        logic           o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_now();
        return 32'({result, flag_zero, flag_neg, flag_ovf});
    endfunction

    // Reference: exact integer result of the operation, truncated to 2*W bits.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [W-1:0] ua,
                                          input logic [W-1:0] ub);
        logic signed [W-1:0] sa4, sb4, t;
        int sa, sb, e;
        logic [2*W-1:0] r;
        logic z, n, o;
        sa4 = ua; sb4 = ub; sa = sa4; sb = sb4;
        case (op)
            3'd0: e = sa + sb;
            3'd1: e = sa - sb;
            3'd2: begin t = sa4 & sb4; e = t; end
            3'd3: begin t = sa4 | sb4; e = t; end
            3'd4: e = sa * sb;
            3'd5: e = sa * 2;
            3'd6: e = sa >>> 1;
            default: begin t = sa4 ^ sb4; e = t; end
        endcase
        r = e[2*W-1:0];
        o = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5) &&
            (e < -(1 << (W-1)) || e > (1 << (W-1)) - 1);
        z = (r == '0);
        n = r[2*W-1];
        if (!FLAGS_ON) begin z = 1'b0; n = 1'b0; o = 1'b0; end
        return 32'({r, z, n, o});
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Issues one op with out_ready high; multiply must hold in_ready low for W cycles
    // and register its product on the W-th edge after acceptance.
    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        logic [31:0] exp;
        nm = $sformatf("vec%0d_op%0d", idx, v.op);
        exp = 32'({v.res, v.z & FLAGS_ON, v.n & FLAGS_ON, v.o & FLAGS_ON});
        wait_ready(nm);
        in_valid = 1'b1; opcode = v.op; a = v.a; b = v.b;
        @(negedge clk);
        in_valid = 1'b0;
        if (v.op == 3'd4) begin
            for (int k = 0; k < W; k++) begin
                check({nm, "_busy"}, 32'({in_ready, out_valid}), 32'd0);
                @(negedge clk);
            end
        end
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_out"}, outs_now(), exp);
    endtask

    vec_t vecs[12];
    logic [31:0] q[$];
    logic [31:0] held, e1;
    bit seen;
    int guard;

    initial begin
        vecs[0]  = '{3'd0, 4'd7,  4'd1,  8'h08, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'd1, 4'h8,  4'd1,  8'hF7, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{3'd2, 4'd5,  4'hA,  8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 4'h8,  4'h8,  8'h40, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'd5, 4'h9,  4'd0,  8'hF2, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'd6, 4'h9,  4'd0,  8'hFC, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'd3, 4'd3,  4'hC,  8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd7, 4'd7,  4'd7,  8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 4'd7,  4'h8,  8'hC8, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{3'd4, 4'd0,  4'd5,  8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd4, 4'hF,  4'hF,  8'h01, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd0, 4'h8,  4'h8,  8'hF0, 1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({out_valid, in_ready, result, flag_zero, flag_neg, flag_ovf}),
              32'({1'b0, 1'b1, 8'h00, 3'b000}));

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Backpressure: result held, then transfer and acceptance on one edge, back-to-back.
        @(negedge clk);
        out_ready = 1'b0;
        wait_ready("bp");
        in_valid = 1'b1; opcode = 3'd0; a = 4'd3; b = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        held = outs_now();
        check("bp_first", held, model(3'd0, 4'd3, 4'd2));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold", outs_now(), held);
            check("bp_stall", 32'({out_valid, in_ready}), 32'b10);
        end
        in_valid = 1'b1; opcode = 3'd1; a = 4'd2; b = 4'd5; out_ready = 1'b1;
        #1 check("bp_same_edge_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        e1 = outs_now();
        check("bp_next", e1, model(3'd1, 4'd2, 4'd5));
        check("bp_next_valid", 32'(out_valid), 32'd1);
        opcode = 3'd7; a = 4'd6; b = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_nogap", 32'({out_valid, outs_now()}), 32'({1'b1, model(3'd7, 4'd6, 4'd3)}));
        @(negedge clk);

        // Reset in the second cycle of a multiply: nothing emitted afterwards.
        wait_ready("rstmul");
        in_valid = 1'b1; opcode = 3'd4; a = 4'd7; b = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmul_after", 32'({out_valid, in_ready, result}), 32'({1'b0, 1'b1, 8'h00}));
        seen = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rstmul_no_stale", 32'(seen), 32'd0);

        // Randomized streaming with random backpressure against the reference model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = 3'($urandom_range(0, 7));
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_unexpected_out", 32'(out_valid), 32'd0);
                else check("rand_out", outs_now(), q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(opcode, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            #1;
            if (out_valid) check("drain_out", outs_now(), q.pop_front());
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
